// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: access size codes, FSM states,
// the latched response record and the request classifier.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC1 = 2'd1,
        ST_ACC2 = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CL_SINGLE = 2'd0,
        CL_SPLIT  = 2'd1,
        CL_ERR    = 2'd2
    } class_e;

    // Everything the response phase needs to know about the granted request.
    typedef struct packed {
        logic port;
        logic we;
        logic split;
        logic err;
    } rsp_rec_t;

    function automatic class_e classify(input logic [1:0] size, input logic [1:0] offs);
        if (size == SZ_ILL || (size == SZ_WORD && offs != 2'b00)) return CL_ERR;
        if (size == SZ_HALF && offs == 2'b11) return CL_SPLIT;
        return CL_SINGLE;
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way grant for the dmem port: round-robin on contention when RR_EN=1,
// otherwise port 0 always wins. rr_last remembers the most recent winner.
module dmem_rr_arb #(
    parameter int RR_EN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic rr_last_q, rr_last_d;

    // NOTE: every output and next-state value gets a default first, so no path
    // through the block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rr_last_d = rr_last_q;
        if (en) begin
            if (req0 && req1) begin
                if ((RR_EN != 0) && !rr_last_q) gnt1 = 1'b1;
                else                            gnt0 = 1'b1;
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
        if (gnt0)      rr_last_d = 1'b0;
        else if (gnt1) rr_last_d = 1'b1;
    end

    // Reset value 1 means "port 1 went last", so port 0 is favoured first.
    // NOTE: state registers use non-blocking assignment so every flop samples
    // its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_last_q <= 1'b1;
        else      rr_last_q <= rr_last_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single dmem port between the load/store unit (port 0) and the
// debug loader (port 1); splits word-straddling halfwords, rejects bad sizes.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wd0,
    input  logic [31:0]       wd1,
    input  logic [1:0]        be0,
    input  logic [1:0]        be1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rsp_valid0,
    output logic              rsp_valid1,
    output logic              rsp_err0,
    output logic              rsp_err1,
    output logic [31:0]       rsp_rd,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_a,
    output logic [31:0]       dmem_wd,
    output logic [1:0]        dmem_be,
    input  logic [31:0]       dmem_rd
);

    state_e            state_q, state_d;
    rsp_rec_t          rec_q, rec_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wd_hi_q, wd_hi_d;
    logic [31:0]       word0_q, word0_d;
    logic [7:0]        word1_q, word1_d;
    logic [ADDR_W-1:0] dmem_a_q, dmem_a_d;
    logic [31:0]       dmem_wd_q, dmem_wd_d;
    logic [1:0]        dmem_be_q, dmem_be_d;

    logic              grant_en;
    logic              sel_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wd;
    logic [1:0]        sel_be;
    class_e            sel_cls;

    // Grants are held off while reset is asserted so none can leak out.
    assign grant_en = (state_q == ST_IDLE) && rst;

    dmem_rr_arb #(.RR_EN(RR_EN)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .en   (grant_en),
        .req0 (req0),
        .req1 (req1),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign sel_port = gnt1;
    assign sel_we   = sel_port ? we1   : we0;
    assign sel_addr = sel_port ? addr1 : addr0;
    assign sel_wd   = sel_port ? wd1   : wd0;
    assign sel_be   = sel_port ? be1   : be0;
    assign sel_cls  = classify(sel_be, sel_addr[1:0]);

    always_comb begin
        state_d   = state_q;
        rec_d     = rec_q;
        addr_d    = addr_q;
        wd_hi_d   = wd_hi_q;
        word0_d   = word0_q;
        word1_d   = word1_q;
        dmem_a_d  = dmem_a_q;
        dmem_wd_d = dmem_wd_q;
        dmem_be_d = dmem_be_q;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt0 || gnt1) begin
                    rec_d.port  = sel_port;
                    rec_d.we    = sel_we;
                    rec_d.split = (sel_cls == CL_SPLIT);
                    rec_d.err   = (sel_cls == CL_ERR);
                    addr_d      = sel_addr;
                    wd_hi_d     = sel_wd[15:8];
                    if (sel_cls == CL_ERR) begin
                        state_d = ST_RESP;
                    end else begin
                        // The dmem bus is loaded one edge early so it is
                        // already stable for the whole ACC1 cycle.
                        dmem_a_d = sel_addr;
                        if (sel_cls == CL_SPLIT) begin
                            dmem_be_d = SZ_BYTE;
                            dmem_wd_d = {24'b0, sel_wd[7:0]};
                        end else begin
                            dmem_be_d = sel_be;
                            dmem_wd_d = sel_wd;
                        end
                        state_d = ST_ACC1;
                    end
                end
            end
            ST_ACC1: begin
                word0_d = dmem_rd;
                if (rec_q.split) begin
                    dmem_a_d  = addr_q + ADDR_W'(1);
                    dmem_be_d = SZ_BYTE;
                    dmem_wd_d = {24'b0, wd_hi_q};
                    state_d   = ST_ACC2;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_ACC2: begin
                word1_d = dmem_rd[7:0];
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            rec_q     <= '0;
            addr_q    <= '0;
            wd_hi_q   <= '0;
            word0_q   <= '0;
            word1_q   <= '0;
            dmem_a_q  <= '0;
            dmem_wd_q <= '0;
            dmem_be_q <= SZ_WORD;
        end else begin
            state_q   <= state_d;
            rec_q     <= rec_d;
            addr_q    <= addr_d;
            wd_hi_q   <= wd_hi_d;
            word0_q   <= word0_d;
            word1_q   <= word1_d;
            dmem_a_q  <= dmem_a_d;
            dmem_wd_q <= dmem_wd_d;
            dmem_be_q <= dmem_be_d;
        end
    end

    // Write enable is decoded from state so an async reset kills it at once.
    assign dmem_we = rec_q.we && (state_q == ST_ACC1 || state_q == ST_ACC2);
    assign dmem_a  = dmem_a_q;
    assign dmem_wd = dmem_wd_q;
    assign dmem_be = dmem_be_q;

    assign rsp_valid0 = (state_q == ST_RESP) && !rec_q.port;
    assign rsp_valid1 = (state_q == ST_RESP) &&  rec_q.port;
    assign rsp_err0   = rsp_valid0 && rec_q.err;
    assign rsp_err1   = rsp_valid1 && rec_q.err;

    // A split load reassembles byte 3 of the first word and byte 0 of the next.
    always_comb begin
        rsp_rd = '0;
        if (state_q == ST_RESP && !rec_q.we && !rec_q.err) begin
            rsp_rd = rec_q.split ? {16'b0, word1_q, word0_q[31:24]} : word0_q;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected responses are queued at grant
// time and popped when rsp_valid* fires; a byte-array dmem model serves reads.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wd0 = '0, wd1 = '0;
    logic [1:0]  be0 = 2'b10, be1 = 2'b10;

    logic        gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, dmem_we;
    logic [31:0] rsp_rd, dmem_a, dmem_wd, dmem_rd;
    logic [1:0]  dmem_be;

    logic        f_gnt0, f_gnt1, f_rsp_valid0, f_rsp_valid1, f_rsp_err0, f_rsp_err1, f_dmem_we;
    logic [31:0] f_rsp_rd, f_dmem_a, f_dmem_wd;
    logic [1:0]  f_dmem_be;
    logic [31:0] zero_rd = '0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        bit          port;
        bit          err;
        bit          chk_rd;
        logic [31:0] rd;
    } exp_t;
    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  be;
        int          cyc;
    } wr_t;

    exp_t sb[$];
    wr_t  wlog[$];
    logic [7:0] mem [0:1023];

    dmem_arbiter #(.ADDR_W(32), .RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1), .be0(be0), .be1(be1),
        .gnt0(gnt0), .gnt1(gnt1), .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
        .rsp_err0(rsp_err0), .rsp_err1(rsp_err1), .rsp_rd(rsp_rd),
        .dmem_we(dmem_we), .dmem_a(dmem_a), .dmem_wd(dmem_wd), .dmem_be(dmem_be),
        .dmem_rd(dmem_rd)
    );

    dmem_arbiter #(.ADDR_W(32), .RR_EN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wd0(wd0), .wd1(wd1), .be0(be0), .be1(be1),
        .gnt0(f_gnt0), .gnt1(f_gnt1), .rsp_valid0(f_rsp_valid0), .rsp_valid1(f_rsp_valid1),
        .rsp_err0(f_rsp_err0), .rsp_err1(f_rsp_err1), .rsp_rd(f_rsp_rd),
        .dmem_we(f_dmem_we), .dmem_a(f_dmem_a), .dmem_wd(f_dmem_wd), .dmem_be(f_dmem_be),
        .dmem_rd(zero_rd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // dmem model: byte-enable BRAM indexed by the low 10 address bits.
    always @(posedge clk) begin
        if (dmem_we) begin
            case (dmem_be)
                2'b00: mem[dmem_a[9:0]] <= dmem_wd[7:0];
                2'b01: begin
                    mem[dmem_a[9:0]] <= dmem_wd[7:0];
                    mem[{dmem_a[9:2], dmem_a[1:0] + 2'd1}] <= dmem_wd[15:8];
                end
                2'b10: for (int i = 0; i < 4; i++) mem[{dmem_a[9:2], 2'b00} + 10'(i)] <= dmem_wd[8*i +: 8];
                default: ;
            endcase
        end
    end

    always_comb dmem_rd = {mem[{dmem_a[9:2], 2'd3}], mem[{dmem_a[9:2], 2'd2}],
                           mem[{dmem_a[9:2], 2'd1}], mem[{dmem_a[9:2], 2'd0}]};

    // Response monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (dmem_we) wlog.push_back('{dmem_a, dmem_wd, dmem_be, cyc});
        if (gnt0 && gnt1) begin
            failures++;
            $display("FAIL dual_grant cyc=%0d gnt0=%b gnt1=%b required at most one", cyc, gnt0, gnt1);
        end
        for (int p = 0; p < 2; p++) begin
            logic v, er;
            v  = (p == 0) ? rsp_valid0 : rsp_valid1;
            er = (p == 0) ? rsp_err0   : rsp_err1;
            if (v) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp cyc=%0d port=%0d err=%b rd=%h", cyc, p, er, rsp_rd);
                end else begin
                    e = sb.pop_front();
                    if (e.port !== p[0] || e.err !== er || (e.chk_rd && e.rd !== rsp_rd)) begin
                        failures++;
                        $display("FAIL rsp cyc=%0d got port=%0d err=%b rd=%h, required port=%0d err=%b rd=%h",
                                 cyc, p, er, rsp_rd, e.port, e.err, e.rd);
                    end
                end
            end
        end
    end

    task automatic set_port(input bit p, input bit r, input bit w, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] b);
        if (!p) begin req0 = r; we0 = w; addr0 = a; wd0 = d; be0 = b; end
        else    begin req1 = r; we1 = w; addr1 = a; wd1 = d; be1 = b; end
    endtask

    task automatic push_exp(input bit p, input bit err, input logic [31:0] rd);
        exp_t e;
        e.port = p; e.err = err; e.chk_rd = !err; e.rd = rd;
        sb.push_back(e);
    endtask

    // Entered and left just after a rising edge.
    task automatic do_txn(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] b, input bit exp_err, input logic [31:0] exp_rd,
                          output int t_gnt);
        bit got = 0;
        t_gnt = -1;
        set_port(p, 1'b1, w, a, d, b);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((p ? gnt1 : gnt0) === 1'b1) begin
                got = 1; t_gnt = cyc;
                push_exp(p, exp_err, exp_rd);
            end
            @(posedge clk); #1;
        end
        set_port(p, 1'b0, w, a, d, b);
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL grant_timeout port=%0d addr=%h got no gnt, required gnt", p, a);
        end
    endtask

    task automatic wait_rsp(input bit p, output int t);
        t = -1;
        for (int i = 0; i < 10 && t < 0; i++) begin
            @(negedge clk);
            if ((p ? rsp_valid1 : rsp_valid0) === 1'b1) t = cyc;
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_lat(input string name, input int tg, input int tr, input int lat);
        checks++;
        if (tr < 0 || tr - tg != lat) begin
            failures++;
            $display("FAIL %s latency got %0d required %0d", name, (tr < 0) ? -1 : tr - tg, lat);
        end
    endtask

    task automatic chk_wr(input string name, input int idx, input logic [31:0] a,
                          input logic [31:0] d, input int c);
        checks++;
        if (wlog.size() <= idx) begin
            failures++;
            $display("FAIL %s write %0d missing (log size %0d)", name, idx, wlog.size());
        end else if (wlog[idx].a !== a || wlog[idx].wd !== d || wlog[idx].be !== 2'b00 && c < 0
                     || wlog[idx].cyc != ((c < 0) ? wlog[idx].cyc : c)) begin
            failures++;
            $display("FAIL %s write %0d got a=%h wd=%h cyc=%0d required a=%h wd=%h cyc=%0d",
                     name, idx, wlog[idx].a, wlog[idx].wd, wlog[idx].cyc, a, d, c);
        end
    endtask

    task automatic drain(input string name);
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s pending responses got %0d required 0", name, sb.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        req0 = 1'b1;
        repeat (2) @(negedge clk);
        checks += 5;
        if ({gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, dmem_we} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got %b required 0000000",
                     {gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err0, rsp_err1, dmem_we});
        end
        if (dmem_a !== 32'h0)   begin failures++; $display("FAIL reset_dmem_a got %h required 0", dmem_a); end
        if (dmem_wd !== 32'h0)  begin failures++; $display("FAIL reset_dmem_wd got %h required 0", dmem_wd); end
        if (rsp_rd !== 32'h0)   begin failures++; $display("FAIL reset_rsp_rd got %h required 0", rsp_rd); end
        if (dmem_be !== 2'b10)  begin failures++; $display("FAIL reset_dmem_be got %b required 10", dmem_be); end
        req0 = 1'b0;
        rst  = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_word();
        int tg, tr;
        wlog.delete();
        do_txn(0, 1, 32'h10, 32'hDEADBEEF, 2'b10, 0, 32'h0, tg);
        wait_rsp(0, tr);
        chk_lat("word_store", tg, tr, 2);
        checks++;
        if (wlog.size() != 1 || wlog[0].a !== 32'h10 || wlog[0].wd !== 32'hDEADBEEF
            || wlog[0].be !== 2'b10 || wlog[0].cyc != tg + 1) begin
            failures++;
            $display("FAIL word_store_write log_size=%0d required one write a=10 wd=deadbeef at T+1", wlog.size());
        end
        do_txn(0, 0, 32'h10, 32'h0, 2'b10, 0, 32'hDEADBEEF, tg);
        wait_rsp(0, tr);
        chk_lat("word_load", tg, tr, 2);
    endtask

    task automatic test_split();
        int tg, tr;
        wlog.delete();
        do_txn(0, 1, 32'h23, 32'h0000ABCD, 2'b01, 0, 32'h0, tg);
        wait_rsp(0, tr);
        chk_lat("split_store", tg, tr, 3);
        chk_wr("split_lo", 0, 32'h23, 32'h000000CD, tg + 1);
        chk_wr("split_hi", 1, 32'h24, 32'h000000AB, tg + 2);
        do_txn(0, 0, 32'h23, 32'h0, 2'b01, 0, 32'h0000ABCD, tg);
        wait_rsp(0, tr);
        chk_lat("split_load", tg, tr, 3);
        // Highest address: the second byte wraps to address 0.
        wlog.delete();
        do_txn(1, 1, 32'hFFFFFFFF, 32'h00001234, 2'b01, 0, 32'h0, tg);
        wait_rsp(1, tr);
        chk_wr("wrap_lo", 0, 32'hFFFFFFFF, 32'h00000034, tg + 1);
        chk_wr("wrap_hi", 1, 32'h00000000, 32'h00000012, tg + 2);
        do_txn(1, 0, 32'hFFFFFFFF, 32'h0, 2'b01, 0, 32'h00001234, tg);
        wait_rsp(1, tr);
    endtask

    task automatic test_errors();
        int tg, tr;
        wlog.delete();
        do_txn(0, 1, 32'h42, 32'h12345678, 2'b10, 1, 32'h0, tg);
        wait_rsp(0, tr);
        chk_lat("err_misaligned", tg, tr, 1);
        do_txn(0, 0, 32'h40, 32'h0, 2'b11, 1, 32'h0, tg);
        wait_rsp(0, tr);
        chk_lat("err_illegal_size", tg, tr, 1);
        checks++;
        if (wlog.size() != 0) begin
            failures++;
            $display("FAIL err_no_write got %0d writes required 0", wlog.size());
        end
    endtask

    task automatic test_contention();
        int seq[$];
        int fp0 = 0, fp1 = 0;
        bit fp_late = 0;
        do_reset();
        set_port(0, 1, 0, 32'h10, 32'h0, 2'b10);
        set_port(1, 1, 0, 32'h24, 32'h0, 2'b00);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (gnt0) begin seq.push_back(0); push_exp(0, 0, 32'hDEADBEEF); end
            if (gnt1) begin seq.push_back(1); push_exp(1, 0, 32'h000000AB); end
            if (f_gnt0) fp0++;
            if (f_gnt1) fp1++;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (seq.size() <= k || seq[k] != (k % 2)) begin
                failures++;
                $display("FAIL rr_order grant %0d got %0d required %0d", k, (seq.size() > k) ? seq[k] : -1, k % 2);
            end
        end
        checks++;
        if (fp0 < 4 || fp1 != 0) begin
            failures++;
            $display("FAIL fixed_prio got port0=%0d port1=%0d grants required port0>=4 port1=0", fp0, fp1);
        end
        set_port(0, 0, 0, 32'h10, 32'h0, 2'b10);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gnt0) push_exp(0, 0, 32'hDEADBEEF);
            if (gnt1) push_exp(1, 0, 32'h000000AB);
            if (f_gnt1) fp_late = 1;
            @(posedge clk); #1;
        end
        set_port(1, 0, 0, 32'h24, 32'h0, 2'b00);
        checks++;
        if (!fp_late) begin
            failures++;
            $display("FAIL fixed_prio_release got no port1 grant required one after req0 drop");
        end
        drain("contention");
    endtask

    task automatic test_reset_mid();
        int  tg = -1;
        bit  got1 = 0;
        set_port(0, 1, 1, 32'h33, 32'h00005566, 2'b01);
        for (int i = 0; i < 10 && tg < 0; i++) begin
            @(negedge clk);
            if (gnt0) tg = cyc;
            @(posedge clk); #1;
        end
        set_port(0, 0, 1, 32'h33, 32'h00005566, 2'b01);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tg < 0 || cyc != tg + 2 || dmem_we !== 1'b1 || dmem_a !== 32'h34) begin
            failures++;
            $display("FAIL acc2_drive got we=%b a=%h required we=1 a=00000034 in ACC2", dmem_we, dmem_a);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (dmem_we !== 1'b0 || rsp_valid0 !== 1'b0 || dmem_be !== 2'b10) begin
            failures++;
            $display("FAIL reset_abort got we=%b valid0=%b be=%b required 0 0 10", dmem_we, rsp_valid0, dmem_be);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        set_port(0, 1, 0, 32'h10, 32'h0, 2'b10);
        set_port(1, 1, 0, 32'h24, 32'h0, 2'b00);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_first got gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
        end
        if (gnt0) push_exp(0, 0, 32'hDEADBEEF);
        if (gnt1) push_exp(1, 0, 32'h000000AB);
        @(posedge clk); #1;
        set_port(0, 0, 0, 32'h10, 32'h0, 2'b10);
        for (int i = 0; i < 10 && !got1; i++) begin
            @(negedge clk);
            if (gnt1) begin got1 = 1; push_exp(1, 0, 32'h000000AB); end
            @(posedge clk); #1;
        end
        set_port(1, 0, 0, 32'h24, 32'h0, 2'b00);
        checks++;
        if (!got1) begin
            failures++;
            $display("FAIL waiting_port1 got no grant required grant");
        end
        drain("reset_mid");
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3] = '{32'h100, 32'h104, 32'h108};
        logic [31:0] datas [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
        int g[$], r[$];
        int tg, tr;
        wlog.delete();
        set_port(1, 1, 1, addrs[0], datas[0], 2'b10);
        for (int i = 0; i < 20 && r.size() < 3; i++) begin
            bit gg = 0;
            @(negedge clk);
            if (gnt1) begin gg = 1; g.push_back(cyc); push_exp(1, 0, 32'h0); end
            if (rsp_valid1) r.push_back(cyc);
            @(posedge clk); #1;
            if (gg) begin
                if (g.size() < 3) set_port(1, 1, 1, addrs[g.size()], datas[g.size()], 2'b10);
                else              set_port(1, 0, 1, 32'h0, 32'h0, 2'b10);
            end
        end
        set_port(1, 0, 1, 32'h0, 32'h0, 2'b10);
        checks++;
        if (g.size() != 3 || r.size() != 3) begin
            failures++;
            $display("FAIL b2b_count got grants=%0d rsps=%0d required 3 3", g.size(), r.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (k > 0) chk_lat("b2b_grant_spacing", g[k-1], g[k], 3);
                chk_lat("b2b_rsp", g[k], r[k], 2);
            end
        end
        checks++;
        if (wlog.size() != 3 || wlog[0].wd !== datas[0] || wlog[1].wd !== datas[1] || wlog[2].wd !== datas[2]
            || wlog[1].a !== addrs[1]) begin
            failures++;
            $display("FAIL b2b_writes got %0d writes required 3 with distinct data", wlog.size());
        end
        do_txn(0, 0, 32'h104, 32'h0, 2'b10, 0, 32'h22222222, tg);
        wait_rsp(0, tr);
        chk_lat("b2b_readback", tg, tr, 2);
        drain("back_to_back");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        test_reset();
        test_word();
        test_split();
        test_errors();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data-memory port (dmem: byte-enable BRAM, 32-bit word, word index from addr[9:2]) between two requesters: port 0 = pipeline load/store unit, port 1 = debug/program loader.
- Splits halfword accesses that straddle a word boundary (addr[1:0]=3) into two byte accesses instead of letting dmem wrap within one word.
- Rejects misaligned words.
- Sits between the MEM stage / debug loader and dmem.

Parameters:
- ADDR_W, 32, requester and dmem address width.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  request valid per port.
- we0 / we1  in  1  1 = store, 0 = load.
- addr0 / addr1  in  ADDR_W  byte address.
- wd0 / wd1  in  32  store data, LSB-justified for byte and half.
- be0 / be1  in  2  size: 00 byte, 01 half, 10 word, 11 illegal.
- gnt0 / gnt1  out  1  request accepted this cycle (combinational).
- rsp_valid0 / rsp_valid1  out  1  one-cycle completion pulse, for loads and stores.
- rsp_err0 / rsp_err1  out  1  qualified by rsp_valid; access was rejected.
- rsp_rd  out  32  load data, shared bus, valid with rsp_valid*.
- dmem_we  out  1  dmem write enable.
- dmem_a  out  ADDR_W  dmem byte address.
- dmem_wd  out  32  dmem write data.
- dmem_be  out  2  dmem size code, same encoding as be*.
- dmem_rd  in  32  dmem read data; valid at the rising edge ending the cycle in which dmem_a is driven.

Behaviour:
- Reset (rst=0, async): state=IDLE, rr_last=1 so port 0 is favoured first. gnt*, rsp_valid*, rsp_err*, dmem_we = 0; dmem_a, dmem_wd, rsp_rd = 0; dmem_be = 2'b10.
- Reset asserted mid-operation aborts the transaction. No response is issued, and dmem_we drops immediately.
- Only IDLE may grant. At most one gnt per cycle.
  - RR_EN=1: if both ports request, grant the port not granted last.
  - RR_EN=0: port 0 always wins.
- A granted request is latched (port, we, addr, wd, be). Requester must hold req until gnt; after gnt it may deassert or present the next request.
- FSM states: IDLE, ACC1, ACC2, RESP.
- IDLE -> on grant, classify the request:
  - be=11, or word with addr[1:0]!=0: go to RESP with err=1. No dmem access; dmem_we stays 0.
  - half with addr[1:0]=3: split. Go to ACC1.
  - otherwise: single access. Go to ACC1.
- ACC1:
  - Single access: dmem_a=addr, dmem_be=be, dmem_wd=wd, dmem_we=we.
  - Split: dmem_a=addr, dmem_be=00, dmem_wd={24'b0, wd[7:0]}.
  - At the cycle-end edge, capture dmem_rd into rd_buf.
  - Next state: split -> ACC2; else -> RESP.
- ACC2 (split only): dmem_a=addr+1 (next word, offset 0), dmem_be=00, dmem_wd={24'b0, wd[15:8]}. Capture dmem_rd. Next state RESP.
- RESP: rsp_valid<port>=1 for exactly one cycle, with rsp_err per classification.
  - Single load: rsp_rd = raw word.
  - Split load: rsp_rd = {16'b0, word1[7:0], word0[31:24]}.
  - Stores: rsp_rd = 0.
  - Next state IDLE. Grant is not allowed in RESP.
- Latency (single access): grant at cycle T, dmem driven T+1, response T+2. Split access: response at T+3. Throughput is one transaction per 3 cycles (4 when split).
- Outside ACC1/ACC2, dmem_we=0. dmem_a/dmem_wd hold their last value.
- addr+1 wraps modulo 2^ADDR_W: 0xFFFFFFFF + 1 = 0x0.
- req asserted while the FSM is busy: gnt stays 0, the request waits, and no request is lost.

Decomposition:
- Shared package dmem_pkg:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state encoding;
  - response record fields.
- One sub-module: dmem_rr_arb, a 2-way round-robin/fixed-priority grant with rr_last register.

Test Plan:
- Aligned word store then load, port 0: addr=0x10, wd=0xDEADBEEF, be=10. Expect one dmem_we pulse at T+1 and rsp_valid0 at T+2. Load returns rsp_rd=0xDEADBEEF at T+2.
- Split half store/load: addr=0x23, wd=0x0000ABCD, be=01. Expect two writes, 0x23 with 0xCD and 0x24 with 0xAB, and rsp_valid0 at T+3. Load at 0x23 returns rsp_rd=0x0000ABCD.
- Contention: req0 and req1 both held for 4 transactions. With RR_EN=1 grants alternate 0,1,0,1. With RR_EN=0, port 1 gets no grant until req0 drops.
- Errors: word at 0x42, then be=11 at 0x40. Each gives rsp_err=1 with rsp_valid at T+1, and dmem_we never asserts.
- Reset mid-split: drop rst during ACC2. dmem_we goes 0 immediately, no rsp_valid is issued, state is IDLE. After release, port 0 is granted first.
- Back-to-back: port 1 keeps req1=1 with 3 distinct stores. Grants land at cycles 0, 3, 6, and each rsp_valid1 comes 2 cycles after its grant.
